// File: rtl/seq_divider_16by8_if.sv
// Operand/result bundle for the sequential 16/8 restoring divider.
// The master drives operands and start; the slave returns status and results.
interface seq_divider_16by8_if #(
  parameter int N_DIVIDEND = 16,
  parameter int N_DIVISOR  = 8
);

  logic                  start;
  logic [N_DIVIDEND-1:0] dividend;
  logic [N_DIVISOR-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [N_DIVIDEND-1:0] quotient;
  logic [N_DIVISOR-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/seq_divider_16by8.sv
// Sequential restoring divider: one quotient bit per clock, 16 steps.
// A zero divisor short-circuits to a one-cycle saturated result.
module seq_divider_16by8 #(
  parameter int N_DIVIDEND = 16,
  parameter int N_DIVISOR  = 8
) (
  input logic                clk,
  input logic                rst,
  seq_divider_16by8_if.slave bus
);

  localparam int DW = N_DIVIDEND;
  localparam int VW = N_DIVISOR;
  localparam int RW = VW + 1;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ZDIV
  } state_t;

  state_t        state;
  logic [RW-1:0] r;
  logic [DW-1:0] q;
  logic [VW-1:0] dvsr;
  logic [CW-1:0] cnt;

  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] quot_q;
  logic [VW-1:0] rem_q;
  logic          dbz_q;

  logic [RW:0]   t;
  logic [RW:0]   d;
  logic          ge;
  logic [RW-1:0] r_nxt;
  logic [DW-1:0] q_nxt;

  // R never exceeds the divisor, so its top bit is always zero here
  always_comb begin
    t     = {r, q[DW-1]};
    d     = {2'b00, dvsr};
    ge    = (t >= d);
    r_nxt = RW'(ge ? t - d : t);
    q_nxt = {q[DW-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      r      <= '0;
      q      <= '0;
      dvsr   <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            dvsr   <= bus.divisor;
            q      <= bus.dividend;
            r      <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            dbz_q  <= 1'b0;
            state  <= (bus.divisor == '0) ? ZDIV : RUN;
          end
        end
        RUN: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quot_q <= q_nxt;
            rem_q  <= r_nxt[VW-1:0];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        ZDIV: begin
          quot_q <= '1;
          rem_q  <= '0;
          dbz_q  <= 1'b1;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Bench for seq_divider_16by8: directed cases plus random back-to-back
// products checked against plain integer division.
module tb_seq_divider_16by8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  seq_divider_16by8_if bus ();

  seq_divider_16by8 dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [15:0] dvd,
                                input logic [7:0] dvs,
                                output logic [15:0] eq,
                                output logic [7:0] er,
                                output logic ez);
    if (dvs == 8'd0) begin
      eq = 16'hFFFF;
      er = 8'h00;
      ez = 1'b1;
    end else begin
      eq = dvd / 16'(dvs);
      er = 8'(dvd % 16'(dvs));
      ez = 1'b0;
    end
  endfunction

  // drive operands so they are taken on the next rising edge
  task automatic launch(input logic [15:0] dvd, input logic [7:0] dvs);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    chk("busy_acc", 32'(bus.busy), 32'd1);
    chk("done_acc", 32'(bus.done), 32'd0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) return;
      chk("busy_run", 32'(bus.busy), 32'd1);
    end
    chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [15:0] dvd,
                           input logic [7:0] dvs, input int cyc);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    model(dvd, dvs, eq, er, ez);
    chk({tag, "_lat"}, 32'(cyc), ez ? 32'd1 : 32'd16);
    chk({tag, "_q"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_r"}, 32'(bus.remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] dvd,
                        input logic [7:0] dvs);
    int cyc;
    launch(dvd, dvs);
    wait_done(cyc);
    check_res(tag, dvd, dvs, cyc);
  endtask

  initial begin
    int          cyc;
    int          seen;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prev_q;

    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q", 32'(bus.quotient), 32'd0);
    chk("rst_r", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("fe01", 16'hFE01, 8'hFF);
    @(posedge clk);
    #1 chk("done_drop", 32'(bus.done), 32'd0);

    run_op("d1000", 16'd1000, 8'd7);
    run_op("d5", 16'h0005, 8'h09);
    run_op("zdiv", 16'h1234, 8'h00);
    run_op("ffff", 16'hFFFF, 8'h01);

    // back-to-back random products, launched in each done cycle
    a = 8'($urandom % 255);
    b = 8'(1 + $urandom % 254);
    launch(16'(a * b), b);
    for (int i = 0; i < 1000; i++) begin
      wait_done(cyc);
      chk("b2b_lat", 32'(cyc), 32'd16);
      chk("b2b_q", 32'(bus.quotient), 32'(a));
      chk("b2b_r", 32'(bus.remainder), 32'd0);
      prev_q = bus.quotient;
      if (i < 999) begin
        a = 8'($urandom % 255);
        b = 8'(1 + $urandom % 254);
        launch(16'(a * b), b);
        chk("b2b_hold", 32'(bus.quotient), 32'(prev_q));
      end
    end

    // start during RUN must be ignored
    launch(16'h8000, 8'h03);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
    end
    bus.start    = 1'b1;
    bus.dividend = 16'h1234;
    bus.divisor  = 8'h00;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("ign_busy", 32'(bus.busy), 32'd1);
    wait_done(cyc);
    check_res("ign", 16'h8000, 8'h03, cyc + 5);
    chk("ign_q2aaa", 32'(bus.quotient), 32'h2AAA);
    @(posedge clk);
    #1 chk("ign_idle", 32'(bus.busy), 32'd0);

    // asynchronous reset mid-operation
    launch(16'h1234, 8'h56);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_q", 32'(bus.quotient), 32'd0);
    chk("arst_r", 32'(bus.remainder), 32'd0);
    chk("arst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    chk("arst_quiet", 32'(seen), 32'd0);
    run_op("post", 16'h0064, 8'h0A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
